// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus between the producers (ALU, load unit, multiplier)
// and the register-file write-port arbiter. Fields are flattened per
// requester: requester i occupies bits [i*W +: W] of addr/data.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    // Producers drive requests and observe the grant
    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    // Arbiter observes requests and drives the one-hot grant
    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the integer register file's single write-back
// port among NUM_REQ producers. One write is accepted per cycle; the winner
// is registered and presented on we_p2/addr_p2/din_p2 the following cycle.
// Writes to x0 are accepted but only signalled via a one-cycle x0_drop pulse.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    regfile_wb_arbiter_if.slave   req,
    output logic                  we_p2,
    output logic [ADDR_W-1:0]     addr_p2,
    output logic [DATA_W-1:0]     din_p2,
    output logic                  x0_drop,
    output logic [2:0]            grant_id
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               x0_q, x0_d;
    logic [2:0]         gid_q, gid_d;

    logic [NUM_REQ-1:0] grant;
    logic               xfer;
    logic [PTR_W:0]     cand_sum;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [2:0]         sel_id;

    // Pick the first valid requester at or after rr_ptr (wrapping); flush and reset suppress the grant
    always_comb begin
        grant    = '0;
        xfer     = 1'b0;
        cand_sum = '0;
        cand     = '0;
        win_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand_sum >= NREQ) begin
                cand_sum = cand_sum - NREQ;
            end
            cand = cand_sum[PTR_W-1:0];
            if (!xfer && req.req_valid[cand]) begin
                xfer    = 1'b1;
                win_idx = cand;
            end
        end
        if (flush || !reset) begin
            xfer = 1'b0;
        end
        if (xfer) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign req.req_ready = grant;

    // Steer the winner's address/data/id and compute the pointer that follows it
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_id   = '0;
        ptr_next = rr_ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req.req_data[i*DATA_W +: DATA_W];
                sel_id   = 3'(i);
                ptr_next = (i == NUM_REQ-1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Next state of the output register and round-robin pointer
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        x0_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        gid_d    = gid_q;
        if (xfer) begin
            rr_ptr_d = ptr_next;
            gid_d    = sel_id;
            if (sel_addr != '0) begin
                we_d   = 1'b1;
                addr_d = sel_addr;
                din_d  = sel_data;
            end else begin
                x0_d   = 1'b1;
            end
        end
    end

    // State registers; asynchronous reset clears the in-flight write completely
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            x0_q     <= 1'b0;
            gid_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            x0_q     <= x0_d;
            gid_q    <= gid_d;
        end
    end

    assign we_p2    = we_q;
    assign addr_p2  = addr_q;
    assign din_p2   = din_q;
    assign x0_drop  = x0_q;
    assign grant_id = gid_q;

endmodule
